// File: rtl/stride_counter.sv
`default_nettype none
// ============================================================================
// Module   : stride_counter
// Brief    : Stride counter between runtime lo/hi bounds with wrap, saturate
//            and ping-pong boundary modes. Optional macro
//            STRIDE_CNT_ODD_LOCK_EN constrains the count to odd values.
// Revision : 1.0 - initial release
// ============================================================================
module stride_counter #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4,
  parameter int START  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic              load_i,
  input  logic [WIDTH-1:0]  load_val_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic [WIDTH-1:0]  lo_i,
  input  logic [WIDTH-1:0]  hi_i,
  input  logic [1:0]        mode_i,
  output logic [WIDTH-1:0]  cnt_o,
  output logic              dir_o,
  output logic              wrap_o,
  output logic              sat_o,
  output logic              cfg_err_o
);

  localparam logic [0:0] c_up   = 1'b0;
  localparam logic [0:0] c_down = 1'b1;

  localparam logic [1:0] c_mode_wrap = 2'b00;
  localparam logic [1:0] c_mode_sat  = 2'b01;
  localparam logic [1:0] c_mode_pp   = 2'b10;

  logic [WIDTH-1:0]  w_lo;
  logic [WIDTH-1:0]  w_hi;
  logic [WIDTH-1:0]  w_load_val;
  logic [STEP_W-1:0] w_step;
  logic              w_cfg_err;

`ifdef STRIDE_CNT_ODD_LOCK_EN
  localparam logic [WIDTH-1:0] c_start = WIDTH'(START) | WIDTH'(1);

  // hi_i == 0 leaves no odd value in range, so it is always a config error
  always_comb begin
    w_lo       = lo_i | WIDTH'(1);
    w_load_val = load_val_i | WIDTH'(1);
    w_step     = step_i & ~STEP_W'(1);
    w_hi       = hi_i[0] ? hi_i : (hi_i - WIDTH'(1));
    w_cfg_err  = (lo_i > hi_i) || (hi_i == '0) || (w_lo > w_hi);
  end
`else
  localparam logic [WIDTH-1:0] c_start = WIDTH'(START);

  always_comb begin
    w_lo       = lo_i;
    w_load_val = load_val_i;
    w_step     = step_i;
    w_hi       = hi_i;
    w_cfg_err  = (lo_i > hi_i);
  end
`endif

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [0:0]       dir_q, dir_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;

  logic [WIDTH:0]          w_step_ext;
  logic [WIDTH:0]          w_up;
  logic signed [WIDTH+1:0] w_dn;
  logic                    w_up_gt_hi;
  logic                    w_up_ge_hi;
  logic                    w_dn_le_lo;

  // Extra headroom bits keep the bound checks free of overflow and underflow
  always_comb begin
    w_step_ext = {{(WIDTH+1-STEP_W){1'b0}}, w_step};
    w_up       = {1'b0, cnt_q} + w_step_ext;
    w_dn       = signed'({2'b00, cnt_q}) - signed'({1'b0, w_step_ext});
    w_up_gt_hi = (w_up > {1'b0, w_hi});
    w_up_ge_hi = (w_up >= {1'b0, w_hi});
    w_dn_le_lo = (w_dn <= signed'({2'b00, w_lo}));
  end

  always_comb begin
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    wrap_d = 1'b0;
    sat_d  = sat_q;
    if (load_i) begin
      cnt_d = w_load_val;
      dir_d = c_up;
      sat_d = 1'b0;
    end else if (!w_cfg_err && (mode_i != 2'b11)) begin
      if (mode_i != c_mode_pp) begin
        dir_d = c_up;
      end
      if (en_i) begin
        case (mode_i)
          c_mode_wrap: begin
            sat_d = 1'b0;
            if (w_up_gt_hi) begin
              cnt_d  = w_lo;
              wrap_d = 1'b1;
            end else begin
              cnt_d = w_up[WIDTH-1:0];
            end
          end
          c_mode_sat: begin
            if (w_up_gt_hi) begin
              cnt_d = w_hi;
              sat_d = 1'b1;
            end else begin
              cnt_d = w_up[WIDTH-1:0];
              sat_d = 1'b0;
            end
          end
          c_mode_pp: begin
            sat_d = 1'b0;
            // A zero stride only acts to pull an out-of-range count back to hi
            if (w_step == '0) begin
              if (w_up_gt_hi) begin
                cnt_d = w_hi;
                dir_d = c_down;
              end
            end else if (dir_q == c_up) begin
              if (w_up_ge_hi) begin
                cnt_d = w_hi;
                dir_d = c_down;
              end else begin
                cnt_d = w_up[WIDTH-1:0];
              end
            end else begin
              if (w_dn_le_lo) begin
                cnt_d  = w_lo;
                dir_d  = c_up;
                wrap_d = 1'b1;
              end else begin
                cnt_d = w_dn[WIDTH-1:0];
              end
            end
          end
          default: begin
            cnt_d = cnt_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= c_start;
      dir_q  <= c_up;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign dir_o     = dir_q;
  assign wrap_o    = wrap_q;
  assign sat_o     = sat_q;
  assign cfg_err_o = w_cfg_err;

endmodule
`default_nettype wire
